// File: rtl/rf_wr_ctrl.sv
// Write-port controller for the 2R/1W register file: clears every entry after
// reset or on request, then round-robin arbitrates two requesters onto the port.
module rf_wr_ctrl #(
  parameter int                   BW_DATA   = 32,
  parameter int                   BW_ADDR   = 5,
  parameter logic [BW_DATA-1:0]   INIT_DATA = '0,
  parameter bit                   ZERO_R0   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_req0_valid,
  input  logic [BW_ADDR-1:0] i_req0_addr,
  input  logic [BW_DATA-1:0] i_req0_data,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [BW_ADDR-1:0] i_req1_addr,
  input  logic [BW_DATA-1:0] i_req1_data,
  output logic               o_req1_ready,
  output logic               o_rf_wr_en,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic [BW_DATA-1:0] o_rf_wr_data,
  output logic               o_init_done
);

  localparam int               DEPTH    = 2 ** BW_ADDR;
  localparam logic [BW_ADDR:0] CNT_LAST = (BW_ADDR + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BW_ADDR:0]   cnt_q, cnt_d;
  logic               pri_q, pri_d;
  logic               wr_en_q, wr_en_d;
  logic [BW_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [BW_DATA-1:0] wr_data_q, wr_data_d;
  logic               init_done_q, init_done_d;

  logic               grant0, grant1;
  logic               run_ok;
  logic               accept;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_data;

  // Round-robin: a lone valid requester always wins; on contention pri decides.
  assign grant0 = i_req0_valid & (~i_req1_valid | ~pri_q);
  assign grant1 = i_req1_valid & (~i_req0_valid |  pri_q);

  assign run_ok       = (state_q == ST_RUN) & ~i_clr;
  assign o_req0_ready = run_ok & grant0;
  assign o_req1_ready = run_ok & grant1;

  assign accept   = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);
  assign sel_addr = o_req1_ready ? i_req1_addr : i_req0_addr;
  assign sel_data = o_req1_ready ? i_req1_data : i_req0_data;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    pri_d       = pri_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;

    unique case (state_q)
      ST_INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q[BW_ADDR-1:0];
        wr_data_d = INIT_DATA;
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_clr) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (accept) begin
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          // Writes to r0 complete the handshake but never reach the array.
          wr_en_d   = ~(ZERO_R0 && (sel_addr == '0));
          pri_d     = ~o_req1_ready;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      pri_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pri_q       <= pri_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_rf_wr_en   = wr_en_q;
  assign o_rf_wr_addr = wr_addr_q;
  assign o_rf_wr_data = wr_data_q;
  assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Self-checking bench for rf_wr_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level model and a shadow array.
module tb_rf_wr_ctrl;

  localparam int              BW_DATA   = 32;
  localparam int              BW_ADDR   = 5;
  localparam int              DEPTH     = 2 ** BW_ADDR;
  localparam logic [31:0]     INIT_DATA = 32'h0;
  localparam bit              ZERO_R0   = 1'b1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               v0, v1;
  logic [BW_ADDR-1:0] a0, a1;
  logic [BW_DATA-1:0] d0, d1;
  logic               rdy0, rdy1;
  logic               wr_en;
  logic [BW_ADDR-1:0] wr_addr;
  logic [BW_DATA-1:0] wr_data;
  logic               init_done;

  rf_wr_ctrl #(
    .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .INIT_DATA(INIT_DATA), .ZERO_R0(ZERO_R0)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_clr(clr),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .o_rf_wr_en(wr_en), .o_rf_wr_addr(wr_addr), .o_rf_wr_data(wr_data),
    .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: clearing flag, next clear address, priority, expected outputs.
  bit          m_run;
  int          m_cnt;
  int          m_pri;
  bit          m_en;
  int          m_addr;
  logic [31:0] m_data;
  bit          m_done;
  logic [31:0] gold_rf [DEPTH];
  logic [31:0] dut_rf  [DEPTH];
  bit          got0, got1;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_pri = 0;
    m_en = 0; m_addr = 0; m_data = '0; m_done = 0;
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic cycle();
    bit e0, e1;
    int g, a;
    logic [31:0] d;
    #1;
    e0 = 0; e1 = 0;
    if (m_run && !clr) begin
      if (v0 && v1) begin e0 = (m_pri == 0); e1 = (m_pri == 1); end
      else begin e0 = v0; e1 = v1; end
    end
    check("ready0", rdy0, e0);
    check("ready1", rdy1, e1);
    got0 = rdy0; got1 = rdy1;

    if (!m_run) begin
      m_en = 1; m_addr = m_cnt; m_data = INIT_DATA;
      gold_rf[m_cnt] = INIT_DATA;
      if (m_cnt == DEPTH - 1) begin m_run = 1; m_done = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (clr) begin
      m_run = 0; m_cnt = 0; m_done = 0; m_en = 0;
    end else if (e0 || e1) begin
      g = e1 ? 1 : 0;
      a = g ? int'(a1) : int'(a0);
      d = g ? d1 : d0;
      m_addr = a; m_data = d;
      m_en = !(ZERO_R0 && a == 0);
      if (m_en) gold_rf[a] = d;
      m_pri = 1 - g;
    end else begin
      m_en = 0;
    end

    @(posedge clk);
    #1;
    check("wr_en", wr_en, m_en);
    check("init_done", init_done, m_done);
    if (m_en) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
    if (wr_en) dut_rf[wr_addr] = wr_data;
  endtask

  task automatic idle_inputs();
    clr = 0; v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
  endtask

  initial begin
    int seen_grants [4];
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready0", rdy0, 0);
    check("rst_ready1", rdy1, 0);
    @(negedge clk);
    rst_n = 1;

    // Full clear: 32 ascending writes of INIT_DATA, done after the 32nd edge.
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("clr_addr_seq", wr_addr, i);
    end
    check("init_done_after_clear", init_done, 1);

    // req0 alone.
    v0 = 1; a0 = 5'd3; d0 = 32'hDEADBEEF;
    cycle();
    check("single_ready0", got0, 1);
    check("single_en", wr_en, 1);
    check("single_addr", wr_addr, 3);
    check("single_data", wr_data, 32'hDEADBEEF);
    v0 = 0;
    cycle();
    check("single_en_drop", wr_en, 0);

    // req1 writes r0: consumed, not issued; pri returns to req0.
    v1 = 1; a1 = '0; d1 = 32'h55;
    cycle();
    check("r0_ready1", got1, 1);
    check("r0_en_low", wr_en, 0);
    v1 = 0;

    // Contention: grants alternate 0,1,0,1 and the port stays busy.
    v0 = 1; a0 = 5'd1; d0 = 32'h11;
    v1 = 1; a1 = 5'd2; d1 = 32'h22;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seen_grants[i] = got1 ? 1 : 0;
      check("alt_en", wr_en, 1);
    end
    for (int i = 0; i < 4; i++) check("alt_grant", seen_grants[i], i % 2);
    check("alt_last_data", wr_data, 32'h22);
    v1 = 0;

    // One-cycle clear pulse while req0 waits.
    a0 = 5'd7; d0 = 32'hCAFE0007;
    clr = 1;
    cycle();
    check("clr_blocks_ready0", got0, 0);
    check("clr_done_falls", init_done, 0);
    clr = 0;
    for (int i = 0; i < DEPTH; i++) cycle();
    check("reclear_done", init_done, 1);
    cycle();
    check("post_clear_accept", got0, 1);
    check("post_clear_addr", wr_addr, 7);
    v0 = 0;

    // Reset in the middle of a clear.
    clr = 1;
    cycle();
    clr = 0;
    for (int i = 0; i < 11; i++) cycle();
    check("abort_at_addr10", wr_addr, 10);
    rst_n = 0;
    model_reset();
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_done", init_done, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("restart_addr_seq", wr_addr, i);
    end
    check("restart_done", init_done, 1);

    // Random traffic; requesters hold their request until it is accepted.
    for (int i = 0; i < 1500; i++) begin
      if (!v0 || got0) begin
        v0 = ($urandom_range(0, 9) < 6);
        a0 = BW_ADDR'($urandom); d0 = $urandom;
      end
      if (!v1 || got1) begin
        v1 = ($urandom_range(0, 9) < 6);
        a1 = BW_ADDR'($urandom); d1 = $urandom;
      end
      clr = ($urandom_range(0, 99) < 2);
      got0 = 0; got1 = 0;
      cycle();
    end

    idle_inputs();
    for (int i = 0; i < DEPTH + 4; i++) cycle();
    check("final_run", init_done, 1);
    for (int i = 0; i < DEPTH; i++) check("array_contents", dut_rf[i], gold_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wr_ctrl.md
Name: rf_wr_ctrl

Overview:
- Write-port controller for the 2-read/1-write register file.
- After reset it sequences a clear of every entry to INIT_DATA, since the array itself has no reset.
- It then shares the single write port between two requesters (req0 = execute, req1 = load/writeback) with round-robin arbitration and a valid/ready handshake.
- Its outputs connect directly to the register file's write-enable, write-address and write-data inputs.

Parameters:
- BW_DATA, 32, data width of the write port
- BW_ADDR, 5, address width; depth = 2**BW_ADDR
- INIT_DATA, 0, value written to every entry during clear
- ZERO_R0, 1, when 1, accepted writes to address 0 are consumed but not issued to the port

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_clr  in  1  request re-clear of the whole file (level, sampled in RUN)
- i_req0_valid  in  1  requester 0 has a write
- i_req0_addr  in  BW_ADDR  requester 0 address
- i_req0_data  in  BW_DATA  requester 0 data
- o_req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- i_req1_valid / i_req1_addr / i_req1_data / o_req1_ready  same widths and meaning for requester 1
- o_rf_wr_en  out  1  to register file write enable (registered)
- o_rf_wr_addr  out  BW_ADDR  to register file write address (registered)
- o_rf_wr_data  out  BW_DATA  to register file write data (registered)
- o_init_done  out  1  high while in RUN (registered)

Behaviour:
- Reset (i_rstn=0, async):
  - state=INIT, clear counter cnt=0, priority pointer pri=0 (req0 favoured).
  - o_rf_wr_en=0, o_rf_wr_addr=0, o_rf_wr_data=0, o_init_done=0.
  - Both readies 0 (combinational, from state).
  - Reset asserted mid-clear or mid-run aborts immediately; the sequence restarts from cnt=0 after release.
- INIT:
  - Each rising edge registers o_rf_wr_en=1, o_rf_wr_addr=cnt, o_rf_wr_data=INIT_DATA, then cnt+1.
  - On the edge that issues cnt=2**BW_ADDR-1: state->RUN, o_init_done<=1, cnt<=0.
  - A full clear takes exactly 2**BW_ADDR edges; addresses are issued in ascending order with no gaps.
  - Readies are 0 throughout INIT. i_clr is ignored in INIT.
- RUN arbitration (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: requester pri is granted.
  - o_reqN_ready = (state==RUN) & !i_clr & grantN.
  - At most one ready is high per cycle.
  - Ready never rises for a requester whose valid is low.
- Accept and pointer update:
  - accept = valid & ready. On every accept, pri <= other requester; otherwise pri holds.
  - Requesters must hold valid, addr and data stable until accepted.
  - A starved requester therefore waits at most 1 accept.
- Write issue (RUN):
  - On an accept edge: o_rf_wr_addr/o_rf_wr_data <= the granted request.
  - o_rf_wr_en <= 1, except 0 when ZERO_R0=1 and addr==0.
  - With no accept, o_rf_wr_en <= 0; addr/data hold.
  - Latency: accept at edge k, write presented to the file after edge k, array updated at edge k+1.
  - Throughput: 1 write per cycle.
- Clear request:
  - i_clr high in RUN forces both readies 0 that cycle.
  - At the edge: state->INIT, cnt=0, o_init_done<=0, o_rf_wr_en<=0.
  - Clear writes begin at the following edge.
  - pri is preserved across a clear.
- Widths: cnt is BW_ADDR+1 bits, so the terminal compare does not wrap. There is no arithmetic on data.

Test Plan:
- Reset, release, no requests, BW_ADDR=5 -> 32 consecutive edges with o_rf_wr_en=1, addresses 0..31, data 0; o_init_done=1 after the 32nd edge; readies 0 before that.
- After init, req0 alone valid, addr=3, data=0xDEADBEEF -> o_req0_ready=1 that cycle; next cycle o_rf_wr_en=1, addr=3, data=0xDEADBEEF; the cycle after, o_rf_wr_en=0.
- Both valid continuously (req0 addr=1/data=0x11, req1 addr=2/data=0x22), pri=0 -> grants alternate 0,1,0,1; o_rf_wr_en stays high every cycle.
- ZERO_R0=1, req1 writes addr=0, data=0x55 -> ready=1 and the handshake completes; o_rf_wr_en stays 0; pri flips to 0.
- i_clr pulsed for 1 cycle while req0 is valid -> req0 not accepted; o_init_done falls; 32 clear writes follow; req0 is then accepted.
- i_rstn asserted at clear address 10 -> outputs 0 immediately; after release the clear restarts at address 0 and completes all 32 writes.
